pulse_capture: RTL and testbench

//  Receive side of the pulse_gen sample stream: consumes 16-bit samples on db each dclk,

---
 rtl/pulse_capture_pkg.sv | 15 +
 rtl/pulse_capture_if.sv | 33 +++
 rtl/pulse_capture_acc.sv | 54 +++++
 rtl/pulse_capture.sv | 100 ++++++++++
 tb/tb_pulse_capture.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/pulse_capture_pkg.sv
// Shared types and default widths for the pulse capture receive path.
package pulse_capture_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int SUM_W_DEF  = 32;
   localparam int LEN_W_DEF  = 16;

   // All-ones at default width; narrower accumulators truncate this to their own maximum.
   localparam logic [SUM_W_DEF-1:0] SUM_MAX = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      INTEG = 2'd1,
      DEAD  = 2'd2
   } st_t;
endpackage

// File: rtl/pulse_capture_if.sv
// Sample stream, config and result bundle for pulse_capture; BASELINE_SUB_EN adds the baseline input.
interface pulse_capture_if #(
   parameter int DATA_W = pulse_capture_pkg::DATA_W_DEF,
   parameter int SUM_W  = pulse_capture_pkg::SUM_W_DEF,
   parameter int LEN_W  = pulse_capture_pkg::LEN_W_DEF
) ();
   logic              enable;
   logic [DATA_W-1:0] db;
   logic [DATA_W-1:0] trig_th;
   logic [LEN_W-1:0]  evt_len;
   logic [LEN_W-1:0]  dead_time;
`ifdef BASELINE_SUB_EN
   logic [DATA_W-1:0] baseline;
`endif
   logic              busy;
   logic [SUM_W-1:0]  energy;
   logic [DATA_W-1:0] peak;
   logic              energy_valid;
   logic              energy_sat;
   logic [15:0]       trig_count;

`ifdef BASELINE_SUB_EN
   modport master (output enable, db, trig_th, evt_len, dead_time, baseline,
                   input  busy, energy, peak, energy_valid, energy_sat, trig_count);
   modport slave  (input  enable, db, trig_th, evt_len, dead_time, baseline,
                   output busy, energy, peak, energy_valid, energy_sat, trig_count);
`else
   modport master (output enable, db, trig_th, evt_len, dead_time,
                   input  busy, energy, peak, energy_valid, energy_sat, trig_count);
   modport slave  (input  enable, db, trig_th, evt_len, dead_time,
                   output busy, energy, peak, energy_valid, energy_sat, trig_count);
`endif
endinterface

// File: rtl/pulse_capture_acc.sv
// Saturating window accumulator and peak tracker; *_next outputs show the value after this cycle's load/add.
// Zero latency on the next-value outputs, no backpressure.
module pulse_capture_acc #(
   parameter int DATA_W = 16,
   parameter int SUM_W  = 32
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              load,
   input  logic              add,
   input  logic [DATA_W-1:0] smp,
   output logic [SUM_W-1:0]  sum_next,
   output logic [DATA_W-1:0] peak_next,
   output logic              sat_next
);
   import pulse_capture_pkg::*;

   // Valid for SUM_W up to the default width, which covers all supported builds.
   localparam logic [SUM_W-1:0] SAT_VAL = SUM_W'(SUM_MAX);

   logic [SUM_W-1:0]  sum;
   logic [DATA_W-1:0] peak;
   logic              sat;
   logic [SUM_W:0]    wide;

   assign wide = {1'b0, sum} + {1'b0, SUM_W'(smp)};

   always_comb begin
      sum_next  = sum;
      peak_next = peak;
      sat_next  = sat;
      if (load) begin
         sum_next  = SUM_W'(smp);
         peak_next = smp;
         sat_next  = 1'b0;
      end else if (add) begin
         sat_next  = sat | wide[SUM_W];
         sum_next  = sat_next ? SAT_VAL : wide[SUM_W-1:0];
         peak_next = (smp > peak) ? smp : peak;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         sum  <= '0;
         peak <= '0;
         sat  <= 1'b0;
      end else begin
         sum  <= sum_next;
         peak <= peak_next;
         sat  <= sat_next;
      end
   end
endmodule

// File: rtl/pulse_capture.sv
// Threshold trigger, fixed-window energy/peak capture and dead time; energy_valid exactly evt_len cycles
// after the trigger sample, no backpressure. BASELINE_SUB_EN subtracts a clamped baseline from every sample.
module pulse_capture #(
   parameter int DATA_W = 16,
   parameter int SUM_W  = 32,
   parameter int LEN_W  = 16
) (
   input  logic           dclk,
   input  logic           reset_n,
   pulse_capture_if.slave bus
);
   import pulse_capture_pkg::*;

   st_t               state;
   logic [LEN_W-1:0]  len_l;
   logic [LEN_W-1:0]  dead_l;
   logic [LEN_W-1:0]  cnt;
   logic [DATA_W-1:0] smp;
   logic              trig;
   logic              fin;
   logic [LEN_W-1:0]  fin_dead;
   logic [SUM_W-1:0]  sum_next;
   logic [DATA_W-1:0] peak_next;
   logic              sat_next;

`ifdef BASELINE_SUB_EN
   assign smp = (bus.db > bus.baseline) ? bus.db - bus.baseline : '0;
`else
   assign smp = bus.db;
`endif

   assign trig     = (state == IDLE) && bus.enable && (smp > bus.trig_th);
   // A window of one sample completes on the trigger edge itself.
   assign fin      = (trig && (bus.evt_len <= LEN_W'(1))) ||
                     ((state == INTEG) && (cnt == len_l - LEN_W'(1)));
   assign fin_dead = trig ? bus.dead_time : dead_l;

   pulse_capture_acc #(.DATA_W(DATA_W), .SUM_W(SUM_W)) u_acc (
      .clk       (dclk),
      .clr       (!reset_n),
      .load      (trig),
      .add       (state == INTEG),
      .smp       (smp),
      .sum_next  (sum_next),
      .peak_next (peak_next),
      .sat_next  (sat_next)
   );

   always_ff @(posedge dclk) begin
      if (!reset_n) begin
         state            <= IDLE;
         len_l            <= '0;
         dead_l           <= '0;
         cnt              <= '0;
         bus.busy         <= 1'b0;
         bus.energy       <= '0;
         bus.peak         <= '0;
         bus.energy_valid <= 1'b0;
         bus.energy_sat   <= 1'b0;
         bus.trig_count   <= '0;
      end else begin
         bus.energy_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (trig) begin
                  bus.trig_count <= bus.trig_count + 16'd1;
                  len_l          <= (bus.evt_len == '0) ? LEN_W'(1) : bus.evt_len;
                  dead_l         <= bus.dead_time;
                  cnt            <= LEN_W'(1);
                  state          <= INTEG;
                  bus.busy       <= 1'b1;
               end
            end
            INTEG: cnt <= cnt + LEN_W'(1);
            DEAD: begin
               cnt <= cnt - LEN_W'(1);
               if (cnt == LEN_W'(1)) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
         if (fin) begin
            bus.energy       <= sum_next;
            bus.peak         <= peak_next;
            bus.energy_sat   <= sat_next;
            bus.energy_valid <= 1'b1;
            if (fin_dead == '0) begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end else begin
               state    <= DEAD;
               bus.busy <= 1'b1;
               cnt      <= fin_dead;
            end
         end
      end
   end
endmodule

// File: tb/tb_pulse_capture.sv
// Directed scoreboard bench for pulse_capture: expected events are queued at the trigger sample
// and checked (values and arrival cycle) by a monitor whenever energy_valid is seen.
module tb_pulse_capture;
   logic dclk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   typedef struct {
      int e;
      int p;
      bit s;
      int tc;
      int at;
   } exp_t;
   exp_t sb[$];

   pulse_capture_if #(.DATA_W(16), .SUM_W(20), .LEN_W(16)) bus ();

   pulse_capture #(.DATA_W(16), .SUM_W(20), .LEN_W(16)) dut (
      .dclk    (dclk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 dclk = ~dclk;
   always @(posedge dclk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Called while the trigger sample is being presented: the result is due lat cycles later.
   task automatic push(int e, int p, bit s, int tc, int lat);
      exp_t x;
      x.e  = e;
      x.p  = p;
      x.s  = s;
      x.tc = tc;
      x.at = cyc + lat;
      sb.push_back(x);
   endtask

   task automatic step(int v);
      bus.db = 16'(v);
      @(posedge dclk);
      #1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(0);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge dclk);
         if (bus.energy_valid === 1'b1) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_valid: got energy %0d expected no event (cycle %0d)",
                        bus.energy, cyc);
            end else begin
               x = sb.pop_front();
               chk("energy",     64'(bus.energy),     64'(x.e));
               chk("peak",       64'(bus.peak),       64'(x.p));
               chk("energy_sat", 64'(bus.energy_sat), 64'(x.s));
               chk("trig_count", 64'(bus.trig_count), 64'(x.tc));
               chk("latency",    64'(cyc),            64'(x.at));
            end
         end
      end
   end

   initial begin : driver
      reset_n       = 1'b0;
      bus.enable    = 1'b0;
      bus.db        = '0;
      bus.trig_th   = '0;
      bus.evt_len   = '0;
      bus.dead_time = '0;
`ifdef BASELINE_SUB_EN
      bus.baseline  = '0;
`endif
      repeat (3) @(posedge dclk);
      #1;
      chk("rst_busy",   64'(bus.busy),         64'd0);
      chk("rst_energy", 64'(bus.energy),       64'd0);
      chk("rst_peak",   64'(bus.peak),         64'd0);
      chk("rst_valid",  64'(bus.energy_valid), 64'd0);
      chk("rst_sat",    64'(bus.energy_sat),   64'd0);
      chk("rst_tcount", 64'(bus.trig_count),   64'd0);
      reset_n = 1'b1;
      idle(2);

      // Basic window, dead time 0: 700 re-triggers on the very next sample
      bus.trig_th = 16'd200; bus.evt_len = 16'd4; bus.dead_time = 16'd0; bus.enable = 1'b1;
      step(100);
      push(1800, 600, 1'b0, 1, 4);
      step(300);
      chk("t1_busy", 64'(bus.busy), 64'd1);
      step(400); step(500); step(600);
      push(700, 700, 1'b0, 2, 4);
      step(700);
      idle(6);

      // Constant input: period len+dead = 5, busy low one cycle per period
      bus.evt_len = 16'd2; bus.dead_time = 16'd3;
      for (int i = 0; i < 15; i++) begin
         chk("t2_busy", 64'(bus.busy), (i % 5 != 0) ? 64'd1 : 64'd0);
         if (i % 5 == 0) push(2000, 1000, 1'b0, 3 + i / 5, 2);
         step(1000);
      end
      idle(6);

      // Saturation, then a small event with sat cleared; evt_len change mid-event applies next time
      bus.trig_th = 16'd0; bus.evt_len = 16'd32; bus.dead_time = 16'd0;
      push(20'hFFFFF, 16'hFFFF, 1'b1, 6, 32);
      for (int i = 0; i < 32; i++) begin
         if (i == 5) bus.evt_len = 16'd2;
         step(16'hFFFF);
      end
      push(12, 7, 1'b0, 7, 2);
      step(5); step(7);
      idle(4);

      // Strict threshold compare and enable gating
      bus.trig_th = 16'd200; bus.evt_len = 16'd1;
      step(200);
      push(201, 201, 1'b0, 8, 1);
      step(201);
      idle(3);
      bus.enable = 1'b0;
      step(1000); step(1000); step(1000);
      chk("t4_tcount_gated", 64'(bus.trig_count), 64'd8);
      chk("t4_busy_gated",   64'(bus.busy),       64'd0);
      bus.enable = 1'b1;
      idle(2);

      // evt_len 0 behaves as 1
      bus.evt_len = 16'd0;
      push(300, 300, 1'b0, 9, 1);
      step(300);
      idle(3);

      // Reset in the middle of a len-8 event discards it
      bus.evt_len = 16'd8;
      step(500); step(500);
      reset_n = 1'b0;
      idle(2);
      reset_n = 1'b1;
      chk("t5_energy", 64'(bus.energy),     64'd0);
      chk("t5_peak",   64'(bus.peak),       64'd0);
      chk("t5_tcount", 64'(bus.trig_count), 64'd0);
      chk("t5_busy",   64'(bus.busy),       64'd0);
      chk("t5_sat",    64'(bus.energy_sat), 64'd0);
      chk("t5_valid",  64'(bus.energy_valid), 64'd0);
      push(370, 300, 1'b0, 1, 8);
      step(300);
      for (int i = 0; i < 7; i++) step(10);
      idle(4);

`ifdef BASELINE_SUB_EN
      // Baseline 100: 120->20 no trigger, 180->80 triggers, 90 clamps to 0, 250->150
      bus.baseline = 16'd100; bus.trig_th = 16'd50; bus.evt_len = 16'd3;
      step(120);
      push(230, 150, 1'b0, 2, 3);
      step(180); step(90); step(250);
      idle(4);
      bus.baseline = 16'd0;
`endif

      idle(5);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
